// File: rtl/mux_scan_sequencer.sv
// Round-robin select sequencer for a 4:1 mux: settles on each channel, samples
// the mux output into a 4-bit frame and hands frames off over valid/ready.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic       i_cont,
  input  logic       i_mux_out,
  input  logic       i_frame_ready,
  output logic       o_ctrl1,
  output logic       o_ctrl2,
  output logic [3:0] o_frame,
  output logic       o_frame_valid,
  output logic       o_busy,
  output logic [7:0] o_frame_count
);

  localparam int unsigned CHAN_W   = 2;
  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned FRAME_W  = 4;
  localparam int unsigned COUNT_W  = 8;
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [CHAN_W-1:0]   LAST_CHAN   = CHAN_W'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CHAN_W-1:0]    r_chan, w_chan_nxt;
  logic [SETTLE_W-1:0]  r_settle, w_settle_nxt;
  logic [FRAME_W-1:0]   r_shadow, w_shadow_nxt;
  logic [FRAME_W-1:0]   r_frame, w_frame_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_busy;
  logic [COUNT_W-1:0]   r_count;
  logic                 w_load;
  logic                 w_xfer;

  // Next-state logic: scan sequencing, frame load and handshake bookkeeping
  always_comb begin
    w_state_nxt  = r_state;
    w_chan_nxt   = r_chan;
    w_settle_nxt = r_settle;
    w_shadow_nxt = r_shadow;
    w_frame_nxt  = r_frame;
    w_valid_nxt  = r_valid;
    w_load       = 1'b0;
    w_xfer       = r_valid & i_frame_ready;

    case (r_state)
      IDLE: begin
        w_chan_nxt = '0;
        if (i_start) begin
          w_state_nxt  = SCAN;
          w_settle_nxt = SETTLE_INIT;
        end
      end
      SCAN: begin
        if (r_settle != '0) begin
          w_settle_nxt = r_settle - SETTLE_W'(1);
        end else begin
          w_shadow_nxt[r_chan] = i_mux_out;
          if (r_chan == LAST_CHAN) begin
            if (!r_valid || i_frame_ready) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = WAIT;
            end
          end else begin
            w_chan_nxt   = r_chan + CHAN_W'(1);
            w_settle_nxt = SETTLE_INIT;
          end
        end
      end
      WAIT: begin
        if (i_frame_ready) begin
          w_load = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_chan_nxt  = '0;
      end
    endcase

    // A loaded frame either chains straight into the next scan or parks in IDLE
    if (w_load) begin
      w_frame_nxt  = w_shadow_nxt;
      w_valid_nxt  = 1'b1;
      w_chan_nxt   = '0;
      w_settle_nxt = SETTLE_INIT;
      w_state_nxt  = i_cont ? SCAN : IDLE;
    end else if (w_xfer) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_chan   <= '0;
      r_settle <= '0;
      r_shadow <= '0;
      r_frame  <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_chan   <= w_chan_nxt;
      r_settle <= w_settle_nxt;
      r_shadow <= w_shadow_nxt;
      r_frame  <= w_frame_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= (w_state_nxt != IDLE);
      r_count  <= r_count + COUNT_W'(w_xfer);
    end
  end

  assign o_ctrl1       = r_chan[1];
  assign o_ctrl2       = r_chan[0];
  assign o_frame       = r_frame;
  assign o_frame_valid = r_valid;
  assign o_busy        = r_busy;
  assign o_frame_count = r_count;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer (SETTLE_CYCLES=2): hand-computed
// select timing, frame contents, backpressure, reset and count wrap.
module tb_mux_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic       ready;
  logic [3:0] chans;
  logic       mux_out;
  logic       ctrl1;
  logic       ctrl2;
  logic [3:0] frame;
  logic       valid;
  logic       busy;
  logic [7:0] count;

  int total;
  int bad;

  mux_scan_sequencer #(.SETTLE_CYCLES(2)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_start       (start),
    .i_cont        (cont),
    .i_mux_out     (mux_out),
    .i_frame_ready (ready),
    .o_ctrl1       (ctrl1),
    .o_ctrl2       (ctrl2),
    .o_frame       (frame),
    .o_frame_valid (valid),
    .o_busy        (busy),
    .o_frame_count (count)
  );

  // Behavioural 4:1 mux: chans[i] is the level on channel i
  assign mux_out = chans[{ctrl1, ctrl2}];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    cont  = 1'b0;
    ready = 1'b1;
    chans = 4'b0000;
    tick();
    tick();
    chk("rst_sel",   32'({ctrl1, ctrl2}), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single scan, channels 0..3 = 0,1,0,1
    chans = 4'b1010;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s1_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("s1_sel_k%0d", k), 32'({ctrl1, ctrl2}), 32'(k / 3));
      chk($sformatf("s1_nvalid_k%0d", k), 32'(valid), 32'd0);
      tick();
    end
    chk("s1_valid", 32'(valid), 32'd1);
    chk("s1_frame", 32'(frame), 32'hA);
    chk("s1_busy0", 32'(busy),  32'd0);
    chk("s1_sel0",  32'({ctrl1, ctrl2}), 32'd0);
    chk("s1_cnt0",  32'(count), 32'd0);
    tick();
    chk("s1_cnt1",   32'(count), 32'd1);
    chk("s1_xvalid", 32'(valid), 32'd0);

    // Backpressure in continuous mode
    ready = 1'b0;
    cont  = 1'b1;
    chans = 4'b0110;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("bp_valid1", 32'(valid), 32'd1);
    chk("bp_frame1", 32'(frame), 32'h6);
    chk("bp_busy1",  32'(busy),  32'd1);
    chk("bp_sel1",   32'({ctrl1, ctrl2}), 32'd0);
    chans = 4'b1001;
    repeat (12) tick();
    chk("bp_wait_sel",   32'({ctrl1, ctrl2}), 32'd3);
    chk("bp_wait_busy",  32'(busy),  32'd1);
    chk("bp_wait_frame", 32'(frame), 32'h6);
    chk("bp_wait_valid", 32'(valid), 32'd1);
    repeat (3) tick();
    chk("bp_hold_sel",   32'({ctrl1, ctrl2}), 32'd3);
    chk("bp_hold_frame", 32'(frame), 32'h6);
    chk("bp_hold_cnt",   32'(count), 32'd1);
    chans = 4'b0011;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("bp_rel_frame", 32'(frame), 32'h9);
    chk("bp_rel_valid", 32'(valid), 32'd1);
    chk("bp_rel_cnt",   32'(count), 32'd2);
    chk("bp_rel_sel",   32'({ctrl1, ctrl2}), 32'd0);
    chk("bp_rel_busy",  32'(busy),  32'd1);

    // Completion coinciding with a transfer: no WAIT
    repeat (11) tick();
    chk("sim_pre_frame", 32'(frame), 32'h9);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    cont  = 1'b0;
    chk("sim_frame", 32'(frame), 32'h3);
    chk("sim_valid", 32'(valid), 32'd1);
    chk("sim_cnt",   32'(count), 32'd3);
    chk("sim_sel",   32'({ctrl1, ctrl2}), 32'd0);
    chans = 4'b1100;
    repeat (12) tick();
    chk("cd_wait_sel",  32'({ctrl1, ctrl2}), 32'd3);
    chk("cd_wait_busy", 32'(busy), 32'd1);
    ready = 1'b1;
    tick();
    chk("cd_frame", 32'(frame), 32'hC);
    chk("cd_cnt",   32'(count), 32'd4);
    chk("cd_busy",  32'(busy),  32'd0);
    chk("cd_valid", 32'(valid), 32'd1);
    tick();
    chk("cd_cnt2",   32'(count), 32'd5);
    chk("cd_valid0", 32'(valid), 32'd0);

    // Asynchronous reset mid-scan, then a clean scan of all ones
    chans = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mr_sel_pre", 32'({ctrl1, ctrl2}), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_sel",   32'({ctrl1, ctrl2}), 32'd0);
    chk("mr_busy",  32'(busy),  32'd0);
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_frame", 32'(frame), 32'd0);
    chk("mr_valid", 32'(valid), 32'd0);
    tick();
    rst_n = 1'b1;
    chans = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("mr2_frame", 32'(frame), 32'hF);
    chk("mr2_valid", 32'(valid), 32'd1);
    tick();
    chk("mr2_cnt", 32'(count), 32'd1);

    // Frame counter wrap in continuous mode, stray START ignored
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("wr_cnt0", 32'(count), 32'd0);
    cont  = 1'b1;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12 * 255 + 1 - 5) tick();
    chk("wr_cnt255", 32'(count), 32'd255);
    chk("wr_busy",   32'(busy),  32'd1);
    repeat (12) tick();
    chk("wr_cnt_wrap", 32'(count), 32'd0);
    cont = 1'b0;
    repeat (11) tick();
    chk("wr_end_busy",  32'(busy),  32'd0);
    chk("wr_end_valid", 32'(valid), 32'd1);
    chk("wr_end_frame", 32'(frame), 32'hF);
    tick();
    chk("wr_end_cnt", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
